// File: rtl/tcdm_mem_model.sv
// tcdm_mem_model: multi-port, word-addressed TCDM/L2 memory model for
// PULP-style request/grant masters. Each port is independent; grants can be
// withheld (deterministic alternation or LFSR-random) to stress handshakes.
// Responses arrive exactly one cycle after a grant. Contents live in the
// array "memory" so benches can preload and inspect it hierarchically.
// Optional build macro: TCDM_MODEL_BE_EN enables byte-enable write masking;
// without it every granted write replaces the full word.
module tcdm_mem_model #(
   parameter int          MP        = 2,
   parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
   parameter int          MEM_WORDS = 1024,
   parameter logic [7:0]  STALL_THR = 8'd128
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             randomize_i,
   input  logic             enable_i,
   input  logic             stallable_i,
   input  logic [MP-1:0]    tcdm_req_i,
   output logic [MP-1:0]    tcdm_gnt_o,
   input  logic [MP*32-1:0] tcdm_add_i,
   input  logic [MP-1:0]    tcdm_wen_i,
   input  logic [MP*4-1:0]  tcdm_be_i,
   input  logic [MP*32-1:0] tcdm_data_i,
   output logic [MP-1:0]    tcdm_r_valid_o,
   output logic [MP*32-1:0] tcdm_r_data_o
);

   localparam int          IW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] DEPTH     = 32'(MEM_WORDS);
   localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

   logic [31:0]        memory [MEM_WORDS];

   logic [MP-1:0][15:0] lfsr_r;
   logic [MP-1:0]       toggle_r;
   logic [MP-1:0]       r_valid_r;
   logic [MP*32-1:0]    r_data_r;

   logic [MP-1:0]       stall_s;
   logic [MP-1:0]       gnt_s;
   logic [MP-1:0]       in_range_s;
   logic [29:0]         word_off_s [MP];
   logic [IW-1:0]       idx_s [MP];
   logic                unused_s;

   // 16-bit Fibonacci LFSR step, taps 16,14,13,11
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Byte address to word index, plus range check (low two address bits ignored)
   always_comb begin
      for (int p = 0; p < MP; p++) begin
         word_off_s[p] = tcdm_add_i[p*32+2 +: 30] - BASE_ADDR[31:2];
         idx_s[p]      = word_off_s[p][IW-1:0];
         in_range_s[p] = (tcdm_add_i[p*32 +: 32] >= BASE_ADDR) &&
                         ({2'b00, word_off_s[p]} < DEPTH);
      end
   end

   // Stall decision from registered state only; grant is the sole req->gnt path
   always_comb begin
      stall_s = {MP{1'b0}};
      gnt_s   = {MP{1'b0}};
      for (int p = 0; p < MP; p++) begin
         if (!stallable_i) begin
            stall_s[p] = 1'b0;
         end else if (randomize_i) begin
            stall_s[p] = (lfsr_r[p][7:0] < STALL_THR);
         end else begin
            stall_s[p] = toggle_r[p];
         end
         gnt_s[p] = tcdm_req_i[p] & enable_i & ~stall_s[p] & ~rst_i;
      end
   end

   // Fold bits that carry no meaning for this model into one sink
   always_comb begin
      unused_s = 1'b0;
      for (int p = 0; p < MP; p++) begin
         unused_s = unused_s ^ tcdm_add_i[p*32] ^ tcdm_add_i[p*32+1];
      end
`ifndef TCDM_MODEL_BE_EN
      unused_s = unused_s ^ (^tcdm_be_i);
`endif
   end

   // Stall state: LFSR and toggle advance on every request cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < MP; p++) begin
            lfsr_r[p] <= 16'hACE1 ^ 16'(p);
         end
         toggle_r <= {MP{1'b0}};
      end else begin
         for (int p = 0; p < MP; p++) begin
            if (tcdm_req_i[p]) begin
               lfsr_r[p]   <= lfsr_next(lfsr_r[p]);
               toggle_r[p] <= ~toggle_r[p];
            end
         end
      end
   end

   // Response path: one-cycle latency, read data sampled before same-cycle writes
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid_r <= {MP{1'b0}};
         r_data_r  <= {(MP*32){1'b0}};
      end else begin
         for (int p = 0; p < MP; p++) begin
            r_valid_r[p] <= gnt_s[p];
            if (gnt_s[p]) begin
               if (tcdm_wen_i[p]) begin
                  r_data_r[p*32 +: 32] <= in_range_s[p] ? memory[idx_s[p]] : DEAD_WORD;
               end else begin
                  r_data_r[p*32 +: 32] <= 32'h0000_0000;
               end
            end
         end
      end
   end

   // Storage writes; ascending port order lets the highest port win per byte
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < MP; p++) begin
         if (gnt_s[p] && !tcdm_wen_i[p] && in_range_s[p]) begin
            for (int b = 0; b < 4; b++) begin
`ifdef TCDM_MODEL_BE_EN
               if (tcdm_be_i[p*4+b]) begin
                  memory[idx_s[p]][8*b +: 8] <= tcdm_data_i[p*32+8*b +: 8];
               end
`else
               memory[idx_s[p]][8*b +: 8] <= tcdm_data_i[p*32+8*b +: 8];
`endif
            end
         end
      end
   end

   assign tcdm_gnt_o     = gnt_s;
   assign tcdm_r_valid_o = r_valid_r;
   assign tcdm_r_data_o  = r_data_r;

endmodule

// File: tb/tb_tcdm_mem_model.sv
// Scoreboard bench for tcdm_mem_model: a predictor turns every observed grant
// into an expected response (from a word-array reference model) and a
// separate monitor pops and compares whenever the DUT presents r_valid.
module tb_tcdm_mem_model;

   localparam int          MP    = 2;
   localparam logic [31:0] BASE  = 32'h1C00_0000;
   localparam int          WORDS = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, randomize_m, enable, stallable;
   logic [1:0]  req, wen;
   logic [31:0] add_a [MP];
   logic [31:0] data_a [MP];
   logic [3:0]  be_a [MP];
   logic [63:0] add_f, data_f;
   logic [7:0]  be_f;
   logic [1:0]  gnt, r_valid;
   logic [63:0] r_data_f;

   assign add_f  = {add_a[1], add_a[0]};
   assign data_f = {data_a[1], data_a[0]};
   assign be_f   = {be_a[1], be_a[0]};

   tcdm_mem_model #(.MP(MP), .BASE_ADDR(BASE), .MEM_WORDS(WORDS), .STALL_THR(8'd128)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .randomize_i    (randomize_m),
      .enable_i       (enable),
      .stallable_i    (stallable),
      .tcdm_req_i     (req),
      .tcdm_gnt_o     (gnt),
      .tcdm_add_i     (add_f),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be_f),
      .tcdm_data_i    (data_f),
      .tcdm_r_valid_o (r_valid),
      .tcdm_r_data_o  (r_data_f)
   );

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q [MP][$];
   logic [31:0] ref_mem [WORDS];
   int          req_cnt [MP];
   int          gcnt [MP];
   int          rcnt [MP];
   int          cyc;
   int          n_pass;
   int          n_total;

   exp_t        pred_e;
   int          pred_idx;
   logic        g_exp;

   task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s port%0d: got %h expected %h (cycle %0d)", name, p, act, exp, cyc);
   endtask

   function automatic bit in_rng(input logic [31:0] a, output int idx);
      logic [31:0] off;
      idx = 0;
      if (a < BASE) return 1'b0;
      off = (a - BASE) >> 2;
      idx = int'(off);
      return off < 32'(WORDS);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Predictor: checks grant rule and queues the expected response per grant
   always @(negedge clk) begin
      for (int p = 0; p < MP; p++) begin
         if (stallable && randomize_m && req[p] && enable && !rst) begin
            rcnt[p]++;
            if (gnt[p] === 1'b1) gcnt[p]++;
         end else begin
            g_exp = req[p] && enable && !rst && !(stallable && req_cnt[p][0]);
            chk("gnt", p, 32'(gnt[p]), 32'(g_exp));
         end
         if (gnt[p] === 1'b1) begin
            pred_e.cyc = cyc;
            if (wen[p]) pred_e.data = in_rng(add_a[p], pred_idx) ? ref_mem[pred_idx] : 32'hDEAD_BEEF;
            else        pred_e.data = 32'h0000_0000;
            exp_q[p].push_back(pred_e);
         end
      end
      for (int p = 0; p < MP; p++) begin
         if (gnt[p] === 1'b1 && wen[p] === 1'b0 && in_rng(add_a[p], pred_idx)) begin
            for (int b = 0; b < 4; b++) begin
`ifdef TCDM_MODEL_BE_EN
               if (be_a[p][b]) ref_mem[pred_idx][8*b +: 8] = data_a[p][8*b +: 8];
`else
               ref_mem[pred_idx][8*b +: 8] = data_a[p][8*b +: 8];
`endif
            end
         end
      end
      for (int p = 0; p < MP; p++) begin
         if (rst) req_cnt[p] = 0;
         else if (req[p]) req_cnt[p]++;
      end
   end

   // Monitor: every r_valid must match the response queued one cycle earlier
   always @(negedge clk) begin
      for (int p = 0; p < MP; p++) begin
         if (exp_q[p].size() > 0 && exp_q[p][0].cyc == cyc - 1) begin
            chk("r_valid", p, 32'(r_valid[p]), 32'd1);
            chk("r_data", p, r_data_f[p*32 +: 32], exp_q[p][0].data);
            void'(exp_q[p].pop_front());
         end else if (r_valid[p] !== 1'b0) begin
            chk("r_valid_spurious", p, 32'(r_valid[p]), 32'd0);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 2'b00;
      wen = 2'b00;
      for (int p = 0; p < MP; p++) begin
         add_a[p]  = 32'h0;
         data_a[p] = 32'h0;
         be_a[p]   = 4'h0;
      end
   endtask

   task automatic set_port(input int p, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      req[p]    = r;
      wen[p]    = w;
      add_a[p]  = a;
      data_a[p] = d;
      be_a[p]   = b;
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0)      return BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 7));
      else if (r == 1) return BASE - 32'(4 + 4 * $urandom_range(0, 7));
      else if (r < 8)  return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else             return BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
   endfunction

   logic [5:0]  g_seq;
   int          pulses;
   int          bad;
   logic [31:0] be_exp;

   initial begin
      n_pass = 0; n_total = 0;
      for (int p = 0; p < MP; p++) begin
         req_cnt[p] = 0; gcnt[p] = 0; rcnt[p] = 0;
      end
      rst = 1'b1; enable = 1'b1; stallable = 1'b0; randomize_m = 1'b0;
      idle();
      tick(); tick();
      @(negedge clk);
      for (int p = 0; p < MP; p++) begin
         chk("reset_r_valid", p, 32'(r_valid[p]), 32'd0);
         chk("reset_r_data", p, r_data_f[p*32 +: 32], 32'h0);
      end
      tick();
      rst = 1'b0;

      // Fill every word through the ports so the model and DUT agree
      for (int i = 0; i < WORDS / 2; i++) begin
         set_port(0, 1'b1, 1'b0, BASE + 32'(4 * i), $urandom, 4'hF);
         set_port(1, 1'b1, 1'b0, BASE + 32'(4 * (i + WORDS / 2)), $urandom, 4'hF);
         tick();
      end
      idle(); tick();

      // Basic write on port 1, read back on port 0
      set_port(1, 1'b1, 1'b0, BASE + 32'h10, 32'hCAFE_F00D, 4'hF);
      tick(); idle();
      set_port(0, 1'b1, 1'b1, BASE + 32'h10, 32'h0, 4'h0);
      tick(); idle(); tick();
      chk("mem4_basic", 4, dut.memory[4], 32'hCAFE_F00D);

      // Byte-enable masking
      set_port(0, 1'b1, 1'b0, BASE, 32'h1122_3344, 4'hF);
      tick();
      set_port(0, 1'b1, 1'b0, BASE, 32'hAABB_CCDD, 4'b0101);
      tick(); idle(); tick();
`ifdef TCDM_MODEL_BE_EN
      be_exp = 32'h11BB_33DD;
`else
      be_exp = 32'hAABB_CCDD;
`endif
      chk("mem0_byte_enable", 0, dut.memory[0], be_exp);

      // Deterministic stall: reset, one unstalled request, then alternate
      rst = 1'b1; tick(); rst = 1'b0;
      set_port(0, 1'b1, 1'b1, BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 32'h0, 4'h0);
      tick();
      stallable = 1'b1; randomize_m = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         set_port(0, 1'b1, 1'b1, BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 32'h0, 4'h0);
         @(negedge clk);
         g_seq[i] = gnt[0];
         if (i > 0 && r_valid[0] === 1'b1) pulses++;
         tick();
      end
      idle();
      @(negedge clk);
      if (r_valid[0] === 1'b1) pulses++;
      tick();
      chk("det_stall_pattern", 0, 32'(g_seq), 32'(6'b101010));
      chk("det_stall_pulses", 0, 32'(pulses), 32'd3);

      // Random stalls with random traffic on both ports
      stallable = 1'b1; randomize_m = 1'b1;
      for (int n = 0; n < 10000; n++) begin
         for (int p = 0; p < MP; p++) begin
            set_port(p, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(0, 15)));
         end
         tick();
      end
      idle(); stallable = 1'b0; randomize_m = 1'b0;
      tick(); tick();
      for (int p = 0; p < MP; p++) begin
         chk("rand_req_cycles", p, 32'(rcnt[p]), 32'd10000);
         n_total++;
         if (gcnt[p] * 100 >= rcnt[p] * 45 && gcnt[p] * 100 <= rcnt[p] * 55) n_pass++;
         else $display("FAIL grant_ratio port%0d: got %0d grants of %0d, required 45-55%%", p, gcnt[p], rcnt[p]);
      end

      // Out-of-range accesses
      set_port(0, 1'b1, 1'b1, BASE + 32'(4 * WORDS), 32'h0, 4'h0);
      set_port(1, 1'b1, 1'b1, BASE - 32'd4, 32'h0, 4'h0);
      tick();
      set_port(0, 1'b1, 1'b0, BASE + 32'(4 * WORDS), 32'h5A5A_5A5A, 4'hF);
      set_port(1, 1'b1, 1'b0, BASE - 32'd4, 32'hA5A5_A5A5, 4'hF);
      tick(); idle(); tick();
      chk("oor_mem_first", 0, dut.memory[0], ref_mem[0]);
      chk("oor_mem_last", WORDS - 1, dut.memory[WORDS-1], ref_mem[WORDS-1]);

      // enable_i low blocks every grant
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_port(0, 1'b1, 1'b1, BASE, 32'h0, 4'h0);
         set_port(1, 1'b1, 1'b0, BASE + 32'h40, 32'h1234_5678, 4'hF);
         tick();
      end
      enable = 1'b1; idle(); tick();

      // Same-cycle writes to one word: port 1 wins (per byte)
      set_port(0, 1'b1, 1'b0, BASE + 32'h20, 32'h0123_4567, 4'hF);
      set_port(1, 1'b1, 1'b0, BASE + 32'h20, 32'h89AB_CDEF, 4'hF);
      tick();
      set_port(0, 1'b1, 1'b0, BASE + 32'h24, 32'h1111_1111, 4'hF);
      set_port(1, 1'b1, 1'b0, BASE + 32'h24, 32'h2222_2222, 4'h3);
      tick(); idle(); tick();
      chk("collide_mem8", 8, dut.memory[8], 32'h89AB_CDEF);
      chk("collide_mem9", 9, dut.memory[9], ref_mem[9]);

      // Reset straight after a grant
      set_port(0, 1'b1, 1'b1, BASE + 32'h14, 32'h0, 4'h0);
      tick(); idle();
      rst = 1'b1;
      set_port(1, 1'b1, 1'b0, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF);
      tick();
      rst = 1'b0; idle();
      @(negedge clk);
      for (int p = 0; p < MP; p++) begin
         chk("post_reset_r_valid", p, 32'(r_valid[p]), 32'd0);
         chk("post_reset_r_data", p, r_data_f[p*32 +: 32], 32'h0);
      end
      tick(); tick();
      bad = 0;
      for (int i = 0; i < WORDS; i++) if (dut.memory[i] !== ref_mem[i]) bad++;
      chk("mem_preserved", 0, 32'(bad), 32'd0);

      repeat (3) tick();
      for (int p = 0; p < MP; p++) chk("queue_drained", p, 32'(exp_q[p].size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tcdm_mem_model.md
Name: tcdm_mem_model

Overview:
- Multi-port, word-addressed TCDM/L2 memory model that serves PULP-style TCDM request/grant master ports (e.g. the uDMA read-only and write-only L2 ports).
- Grant stalls are injectable to stress master handshakes.
- Contents are held in an array named memory so benches can preload and check it hierarchically.
- One clock domain. Intended for verification benches; written in synthesizable RTL.

Parameters:
- MP, 2, number of independent master ports.
- BASE_ADDR, 32'h1C000000, byte address that maps to memory[0].
- MEM_WORDS, 1024, depth in 32-bit words.
- STALL_THR, 8'd128, stall threshold in random mode; a port stalls when its LFSR[7:0] < STALL_THR (128 gives 50%).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- randomize_i  in  1  1 = LFSR-random stalls; 0 = deterministic alternating stalls.
- enable_i  in  1  0 = no grants on any port.
- stallable_i  in  1  0 = never stall (gnt follows req).
- tcdm_req_i  in  MP  request per port.
- tcdm_gnt_o  out  MP  grant per port (combinational).
- tcdm_add_i  in  MPx32  byte address per port.
- tcdm_wen_i  in  MP  1 = read, 0 = write.
- tcdm_be_i  in  MPx4  byte enables.
- tcdm_data_i  in  MPx32  write data.
- tcdm_r_valid_o  out  MP  response valid.
- tcdm_r_data_o  out  MPx32  read data.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values:
  - tcdm_r_valid_o = 0 and tcdm_r_data_o = 0.
  - Per-port LFSR = 16'hACE1 ^ port index.
  - Per-port toggle bit = 0.
  - memory is NOT cleared.
  - tcdm_gnt_o is forced 0 while rst_i = 1.
- Grant: gnt[p] = req[p] & enable_i & ~stall[p] & ~rst_i.
  - stall[p] = 0 when stallable_i = 0.
  - Random mode (randomize_i = 1): stall[p] = (lfsr[p][7:0] < STALL_THR).
  - Deterministic mode (randomize_i = 0): stall[p] = toggle[p].
  - stall[p] depends on registered state only; the only combinational path is req to gnt.
- Stall state update:
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in which req[p] = 1.
  - toggle[p] inverts every cycle in which req[p] = 1, so every other request cycle is granted.
- Address decode:
  - idx = (add - BASE_ADDR) >> 2; add[1:0] is ignored.
  - Out of range when add < BASE_ADDR or idx >= MEM_WORDS.
- Write (granted, wen = 0):
  - At the clock edge, each byte b with be[b] = 1 gets data[8b+7:8b]; other bytes are unchanged.
  - Out-of-range writes are dropped.
- Read (granted, wen = 1):
  - Next cycle: r_valid[p] = 1 and r_data[p] = memory[idx] as it was before any same-cycle write (read-before-write).
  - Out-of-range reads return 32'hDEADBEEF.
- Write response: a granted write also pulses r_valid[p] one cycle later, with r_data[p] = 0.
- r_valid[p] = 0 in every cycle not following a grant. r_data[p] holds its last value when no response is issued.
- Latency: exactly 1 cycle grant-to-r_valid. Back-to-back grants give back-to-back r_valid.
- Simultaneous access:
  - Ports are independent; no inter-port arbitration.
  - Multiple ports writing the same word in one cycle: highest port index wins, per byte.
- Reset mid-operation: pending responses are cancelled; r_valid = 0 on the cycle after reset.

Optional Feature:
- Macro: TCDM_MODEL_BE_EN.
- Defined: byte-enable masking on writes as described above.
- Undefined: tcdm_be_i is ignored and every granted write replaces the full 32-bit word.

Test Plan:
- Basic write/read, stallable_i = 0, enable_i = 1:
  - Port 1 writes 32'hCAFEF00D to 0x1C000010, be = 4'hF.
  - Port 0 then reads 0x1C000010.
  - Required: gnt in the same cycle as req; r_valid one cycle later with r_data = CAFEF00D; memory[4] = CAFEF00D.
- Byte enable (TCDM_MODEL_BE_EN defined):
  - memory[0] = 32'h11223344; write 32'hAABBCCDD with be = 4'b0101.
  - Required: memory[0] = 32'h11BB33DD. With the macro undefined: 32'hAABBCCDD.
- Deterministic stall: randomize_i = 0, stallable_i = 1, req held high for 6 cycles.
  - Required: gnt = 0,1,0,1,0,1; exactly 3 r_valid pulses.
- Random stall: randomize_i = 1, STALL_THR = 128, 10000 request cycles.
  - Required: grant ratio within 45-55%; every grant followed by exactly one r_valid.
- Boundaries:
  - Read 0x1C000000 + 4*MEM_WORDS returns DEADBEEF, and a write to it leaves memory unchanged.
  - enable_i = 0 keeps gnt = 0 with req high.
  - Same-cycle writes to one word from ports 0 and 1 leave port 1's data.
- Reset: assert rst_i for 1 cycle immediately after a grant.
  - Required: no r_valid afterwards, r_data = 0, memory contents preserved.
